fc_stream_arbiter: RTL and testbench
====================================

# fc_stream_arbiter

Round-robin scheduler that time-shares one fully-connected engine (`fc_<M>_<N>_...` family, streaming valid/ready on both sides) between NREQ requesters. A requester owns the engine for one whole transaction: the arbiter forwards exactly N input words to the engine, then returns exactly M output words to the same requester. It sits between the upstream stream producers and a single FC engine instance.

## Interface
Parameters:
- WIDTH, 16, data word width (signed, matches engine)
- N, 8, input vector length (words per transaction into engine)
- M, 4, output vector length (words per transaction out of engine)
- NREQ, 2, number of requesters (2..4)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted); released synchronously by the integrator
- req_valid  in  NREQ  per-requester input valid
- req_ready  out  NREQ  per-requester input ready
- req_data  in  NREQ x WIDTH  per-requester input word
- rsp_valid  out  NREQ  per-requester output valid
- rsp_ready  in  NREQ  per-requester output ready
- rsp_data  out  WIDTH  shared output word (qualified by rsp_valid)
- eng_in_valid  out  1  to engine input_valid
- eng_in_ready  in  1  from engine input_ready
- eng_in_data  out  WIDTH  to engine input_data
- eng_out_valid  in  1  from engine output_valid
- eng_out_ready  out  1  to engine output_ready
- eng_out_data  in  WIDTH  from engine output_data
- grant_id  out  $clog2(NREQ)  current/last owner
- busy  out  1  high in FEED or DRAIN

## Operation
- States: IDLE, FEED, DRAIN.
- IDLE: if any req_valid, pick first set bit searching from (last_grant+1) mod NREQ upward with wrap; register grant_id, go FEED. No handshake completes in IDLE; all req_ready, rsp_valid, eng_in_valid, eng_out_ready are 0.
- FEED: eng_in_valid = req_valid[g]; eng_in_data = req_data[g]; req_ready[g] = eng_in_ready; other req_ready 0. Transfer = req_valid[g] & eng_in_ready. in_cnt counts transfers 0..N-1; on transfer with in_cnt==N-1 clear in_cnt, go DRAIN.
- DRAIN: rsp_valid[g] = eng_out_valid; rsp_data = eng_out_data; eng_out_ready = rsp_ready[g]; other rsp_valid 0. out_cnt counts transfers 0..M-1; on last transfer clear out_cnt, last_grant <= g, go IDLE.
- Outside DRAIN eng_out_ready = 0; rsp_data = 0 when no rsp_valid.
- Grant is never revoked mid-transaction: requester dropping req_valid or rsp_ready stalls the arbiter indefinitely, no timeout, no abort.
- Non-owning requesters are ignored (not queued); their valids may stay high.
- Arithmetic: counters unsigned, width $clog2(N) / $clog2(M) (min 1); no data modification.

## Timing
- Reset (reset==0, async): state IDLE, grant_id 0, last_grant NREQ-1 (requester 0 wins first), counters 0, busy 0, all valid/ready outputs 0, rsp_data 0, eng_in_data 0.
- Grant latency: req_valid seen in IDLE at cycle t -> FEED at t+1, first transfer possible at t+1.
- Data paths FEED/DRAIN are combinational pass-through, zero added latency.
- One IDLE cycle always follows DRAIN completion (re-arbitration bubble), even with one active requester.
- Reset mid-transaction: immediate return to IDLE; integrator drives engine reset from the same net (inverted to engine's active-high reset), so no partial vector survives.
- Simultaneous requests: round-robin order strictly from last_grant+1.

## Configuration
- FC_ARB_STATS_EN defined: adds output port done_cnt (NREQ x 16), per-requester count of completed transactions, incremented on last DRAIN transfer, wraps 65535->0, reset to 0.
- Not defined: port and counters absent; all other behaviour identical.

## Structure
- Package fc_arb_pkg: state enum typedef (IDLE/FEED/DRAIN, 2 bits), default WIDTH/N/M constants, stats counter width constant (16).
- Sub-module fc_arb_rr_pick: combinational round-robin picker (req vector, last_grant -> grant index, any flag).

## Test plan
- Single requester 0, N=8 words 1..8, engine stub echoes sum -> 4 rsp words at rsp_valid[0] only; grant_id 0; one idle cycle before next grant.
- Both requesters valid continuously, 4 transactions -> grant order 0,1,0,1; no interleaving of words within any transaction.
- Requester 1 drops req_valid for 3 cycles at word 5 -> eng_in_valid low 3 cycles, grant held, transaction completes with 8 words.
- rsp_ready[0] low during DRAIN -> eng_out_ready low, eng_out_data held; completes after rsp_ready returns.
- reset=0 asserted mid-FEED after word 3 -> all outputs 0 asynchronously; after release next grant goes to requester 0.
- FC_ARB_STATS_EN: 3 transactions on req 0, 2 on req 1 -> done_cnt = {2,3}.

Source files
------------

// File: rtl/fc_arb_pkg.sv
// Shared types and constants for the FC engine stream arbiter.
// State encoding, default geometry and counter-width helper.
package fc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N     = 8;
    localparam int DEF_M     = 4;
    localparam int DEF_NREQ  = 2;
    localparam int STATS_W   = 16;

    // Counter width for a 0..depth-1 range, never narrower than one bit.
    function automatic int cnt_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fc_arb_rr_pick.sv
// Combinational round-robin picker: first requester set at or after
// last_grant+1 (with wrap) wins.
module fc_arb_rr_pick
    import fc_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int GW   = cnt_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last_grant,
    output logic [GW-1:0]   grant,
    output logic            any
);

    logic [GW-1:0] idx_s;

    // Scan farthest offset first so the nearest requester overwrites the rest.
    always_comb begin
        grant = {GW{1'b0}};
        any   = 1'b0;
        idx_s = {GW{1'b0}};
        for (int k = NREQ; k >= 1; k--) begin
            idx_s = GW'((int'(last_grant) + k) % NREQ);
            if (req[idx_s]) begin
                grant = idx_s;
                any   = 1'b1;
            end else begin
                grant = grant;
            end
        end
    end

endmodule

// File: rtl/fc_stream_arbiter.sv
// Round-robin owner of a single streaming FC engine: N words in, M words back.
// Optional per-requester completion counters behind FC_ARB_STATS_EN.
module fc_stream_arbiter
    import fc_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int M     = DEF_M,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [WIDTH-1:0]          rsp_data,
    output logic                      eng_in_valid,
    input  logic                      eng_in_ready,
    output logic [WIDTH-1:0]          eng_in_data,
    input  logic                      eng_out_valid,
    output logic                      eng_out_ready,
    input  logic [WIDTH-1:0]          eng_out_data,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
`ifdef FC_ARB_STATS_EN
    ,
    output logic [NREQ*STATS_W-1:0]   done_cnt
`endif
);

    localparam int GW   = $clog2(NREQ);
    localparam int INW  = cnt_w(N);
    localparam int OUTW = cnt_w(M);
    localparam logic [INW-1:0]  IN_LAST  = INW'(N - 1);
    localparam logic [OUTW-1:0] OUT_LAST = OUTW'(M - 1);

    arb_state_e       state_r, state_s;
    logic [GW-1:0]    grant_r, grant_s;
    logic [GW-1:0]    last_grant_r, last_grant_s;
    logic [GW-1:0]    pick_s;
    logic             pick_any_s;
    logic [INW-1:0]   in_cnt_r, in_cnt_s;
    logic [OUTW-1:0]  out_cnt_r, out_cnt_s;
    logic             fire_in_s, fire_out_s, txn_done_s;

    fc_arb_rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant      (pick_s),
        .any        (pick_any_s)
    );

    // Control state; last_grant resets to NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            grant_r      <= {GW{1'b0}};
            last_grant_r <= GW'(NREQ - 1);
            in_cnt_r     <= {INW{1'b0}};
            out_cnt_r    <= {OUTW{1'b0}};
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            in_cnt_r     <= in_cnt_s;
            out_cnt_r    <= out_cnt_s;
        end
    end

    // Next-state and zero-latency steering of the owner's streams.
    always_comb begin
        state_s       = state_r;
        grant_s       = grant_r;
        last_grant_s  = last_grant_r;
        in_cnt_s      = in_cnt_r;
        out_cnt_s     = out_cnt_r;
        req_ready     = {NREQ{1'b0}};
        rsp_valid     = {NREQ{1'b0}};
        rsp_data      = {WIDTH{1'b0}};
        eng_in_valid  = 1'b0;
        eng_in_data   = {WIDTH{1'b0}};
        eng_out_ready = 1'b0;
        fire_in_s     = 1'b0;
        fire_out_s    = 1'b0;
        txn_done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    grant_s = pick_s;
                    state_s = ST_FEED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                eng_in_valid       = req_valid[grant_r];
                eng_in_data        = req_data[int'(grant_r)*WIDTH +: WIDTH];
                req_ready[grant_r] = eng_in_ready;
                fire_in_s          = req_valid[grant_r] & eng_in_ready;
                if (fire_in_s && (in_cnt_r == IN_LAST)) begin
                    in_cnt_s = {INW{1'b0}};
                    state_s  = ST_DRAIN;
                end else if (fire_in_s) begin
                    in_cnt_s = in_cnt_r + INW'(1);
                end else begin
                    in_cnt_s = in_cnt_r;
                end
            end
            ST_DRAIN: begin
                rsp_valid[grant_r] = eng_out_valid;
                rsp_data           = eng_out_valid ? eng_out_data : {WIDTH{1'b0}};
                eng_out_ready      = rsp_ready[grant_r];
                fire_out_s         = eng_out_valid & rsp_ready[grant_r];
                if (fire_out_s && (out_cnt_r == OUT_LAST)) begin
                    out_cnt_s  = {OUTW{1'b0}};
                    txn_done_s = 1'b1;
                    state_s    = ST_IDLE;
                end else if (fire_out_s) begin
                    out_cnt_s = out_cnt_r + OUTW'(1);
                end else begin
                    out_cnt_s = out_cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (txn_done_s) begin
            last_grant_s = grant_r;
        end else begin
            last_grant_s = last_grant_s;
        end
    end

    assign grant_id = grant_r;
    assign busy     = (state_r != ST_IDLE);

`ifdef FC_ARB_STATS_EN
    logic [STATS_W-1:0] done_cnt_r [NREQ];

    // Completed-transaction counters, wrapping naturally at 2^STATS_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                done_cnt_r[i] <= {STATS_W{1'b0}};
            end
        end else if (txn_done_s) begin
            done_cnt_r[grant_r] <= done_cnt_r[grant_r] + STATS_W'(1);
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_done
        assign done_cnt[gi*STATS_W +: STATS_W] = done_cnt_r[gi];
    end
`endif

endmodule

// File: tb/tb_fc_stream_arbiter.sv
// Bench for fc_stream_arbiter: directed transaction table, reset abort and
// randomized traffic checked against a transaction-level model.
module tb_fc_stream_arbiter;

    localparam int WIDTH = 16;
    localparam int N     = 8;
    localparam int M     = 4;
    localparam int NREQ  = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [WIDTH-1:0]      rsp_data, eng_in_data, eng_out_data;
    logic                  eng_in_valid, eng_in_ready, eng_out_valid, eng_out_ready;
    logic [0:0]            grant_id;
    logic                  busy;
`ifdef FC_ARB_STATS_EN
    logic [NREQ*16-1:0]    done_cnt;
`endif

    always #5 clk = ~clk;

    fc_stream_arbiter #(.WIDTH(WIDTH), .N(N), .M(M), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready), .eng_in_data(eng_in_data),
        .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready), .eng_out_data(eng_out_data),
        .grant_id(grant_id), .busy(busy)
`ifdef FC_ARB_STATS_EN
        , .done_cnt(done_cnt)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    // transaction-level model: owner (-1 = none), words left each way
    int owner_m = -1;
    int last_m  = NREQ - 1;
    int gid_m   = 0;
    int in_left = 0;
    int out_left = 0;
    int done_m[NREQ];
    int seq[NREQ];
    logic fire_in_m, fire_out_m;

    // engine stub: sums N inputs, answers with sum+0 .. sum+M-1
    logic [WIDTH-1:0] outq[$];
    int acc = 0;
    int acc_n = 0;
    logic eng_stall = 1'b0;

    typedef struct {
        logic [NREQ-1:0] mask;
        int exp_g;
        int drop_at;
        int hold;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: cycle budget expired at %0t", name, $time);
    endtask

    task automatic drive_stub();
        for (int i = 0; i < NREQ; i++)
            req_data[i*WIDTH +: WIDTH] = WIDTH'((i << 12) | (seq[i] & 32'hfff));
        eng_out_valid = (outq.size() > 0) && !eng_stall;
        eng_out_data  = (outq.size() > 0) ? outq[0] : WIDTH'($urandom);
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] e_rr, e_rv;
        logic e_eiv, e_eor;
        logic [WIDTH-1:0] e_eid, e_rd;
        e_rr = '0; e_rv = '0; e_eiv = 1'b0; e_eor = 1'b0; e_eid = '0; e_rd = '0;
        if (owner_m >= 0 && in_left > 0) begin
            e_eiv = req_valid[owner_m];
            e_eid = req_data[owner_m*WIDTH +: WIDTH];
            e_rr[owner_m] = eng_in_ready;
        end else if (owner_m >= 0) begin
            e_rv[owner_m] = eng_out_valid;
            e_rd = eng_out_valid ? eng_out_data : '0;
            e_eor = rsp_ready[owner_m];
        end
        chk("req_ready", req_ready, e_rr);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_data", rsp_data, e_rd);
        chk("eng_in_valid", eng_in_valid, e_eiv);
        chk("eng_in_data", eng_in_data, e_eid);
        chk("eng_out_ready", eng_out_ready, e_eor);
        chk("busy", busy, owner_m >= 0);
        chk("grant_id", grant_id, gid_m);
        fire_in_m  = e_eiv & eng_in_ready;
        fire_out_m = (|e_rv) & eng_out_valid & e_eor;
    endtask

    task automatic update_model();
        if (owner_m < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (owner_m < 0 && req_valid[(last_m + k) % NREQ])
                    owner_m = (last_m + k) % NREQ;
            end
            if (owner_m >= 0) begin
                gid_m = owner_m;
                in_left = N;
            end
        end else if (in_left > 0) begin
            if (fire_in_m) begin
                acc += int'(req_data[owner_m*WIDTH +: WIDTH]);
                acc_n++;
                seq[owner_m]++;
                in_left--;
                if (acc_n == N) begin
                    for (int j = 0; j < M; j++) outq.push_back(WIDTH'(acc + j));
                    acc = 0;
                    acc_n = 0;
                end
                if (in_left == 0) out_left = M;
            end
        end else if (fire_out_m) begin
            void'(outq.pop_front());
            out_left--;
            if (out_left == 0) begin
                last_m = owner_m;
                done_m[owner_m]++;
                owner_m = -1;
            end
        end
    endtask

    task automatic cycle();
        drive_stub();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic run_txn(input logic [NREQ-1:0] mask, input int exp_g, input int drop_at, input int hold);
        int drops = 0;
        int holds = 0;
        int budget = 0;
        req_valid = mask; rsp_ready = '1; eng_in_ready = 1'b1; eng_stall = 1'b0;
        while (owner_m < 0 && budget < 20) begin
            cycle();
            budget++;
        end
        if (owner_m < 0) begin
            timeout("grant_wait");
            return;
        end
        chk("txn_grant", grant_id, exp_g);
        chk("txn_busy", busy, 1'b1);
        while (owner_m >= 0 && budget < 200) begin
            req_valid = mask;
            rsp_ready = '1;
            if (in_left > 0 && drop_at >= 0 && (N - in_left) == drop_at && drops < 3) begin
                req_valid[owner_m] = 1'b0;
                drops++;
            end
            if (in_left == 0 && holds < hold) begin
                rsp_ready[owner_m] = 1'b0;
                holds++;
            end
            cycle();
            budget++;
        end
        if (owner_m >= 0) begin
            timeout("txn_complete");
            return;
        end
        chk("bubble_busy", busy, 1'b0);
    endtask

    task automatic model_reset();
        owner_m = -1; last_m = NREQ - 1; gid_m = 0; in_left = 0; out_left = 0;
        acc = 0; acc_n = 0;
        outq.delete();
        for (int i = 0; i < NREQ; i++) done_m[i] = 0;
    endtask

    initial begin
        int budget;
        reset = 1'b0;
        req_valid = '0; rsp_ready = '0; eng_in_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) seq[i] = 0;
        model_reset();
        drive_stub();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant_id, 1'b0);
        chk("rst_eng_in_valid", eng_in_valid, 1'b0);
        chk("rst_eng_out_ready", eng_out_ready, 1'b0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_eng_in_data", eng_in_data, '0);
        reset = 1'b1;

        tbl[0] = '{2'b01, 0, -1, 0};
        tbl[1] = '{2'b11, 1,  5, 0};
        tbl[2] = '{2'b11, 0, -1, 3};
        tbl[3] = '{2'b11, 1, -1, 0};
        tbl[4] = '{2'b10, 1, -1, 0};
        tbl[5] = '{2'b10, 1, -1, 2};
        tbl[6] = '{2'b11, 0,  2, 0};
        tbl[7] = '{2'b01, 0, -1, 0};
        for (int t = 0; t < 8; t++) run_txn(tbl[t].mask, tbl[t].exp_g, tbl[t].drop_at, tbl[t].hold);

`ifdef FC_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) chk("done_cnt_tbl", done_cnt[i*16 +: 16], done_m[i]);
`endif

        // abort requester 1 after its third word, then re-arbitrate from scratch
        req_valid = 2'b10;
        budget = 0;
        while (!(owner_m == 1 && in_left == N - 3) && budget < 50) begin
            cycle();
            budget++;
        end
        if (budget >= 50) timeout("abort_wait");
        #2 reset = 1'b0;
        #1;
        chk("abort_req_ready", req_ready, '0);
        chk("abort_eng_in_valid", eng_in_valid, 1'b0);
        chk("abort_eng_in_data", eng_in_data, '0);
        chk("abort_rsp_valid", rsp_valid, '0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_grant", grant_id, 1'b0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
`ifdef FC_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) chk("done_cnt_rst", done_cnt[i*16 +: 16], 0);
`endif
        run_txn(2'b11, 0, -1, 0);

        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = ($urandom % 4) != 0;
                rsp_ready[i] = ($urandom % 4) != 0;
            end
            eng_in_ready = ($urandom % 4) != 0;
            eng_stall    = ($urandom % 4) == 0;
            cycle();
        end
        req_valid = '0; rsp_ready = '1; eng_in_ready = 1'b1; eng_stall = 1'b0;
        budget = 0;
        while (owner_m >= 0 && budget < 200) begin
            if (in_left > 0) req_valid[owner_m] = 1'b1;
            cycle();
            budget++;
        end
        if (owner_m >= 0) timeout("final_drain");
        cycle();
`ifdef FC_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) chk("done_cnt_final", done_cnt[i*16 +: 16], done_m[i]);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
